// File: rtl/buffer_dma_engine.sv
// Latency-aware load/save engine between external memory and N-bank PE buffers.
// One command at a time; one request per cycle, returns tagged by a valid/address shift register.
module buffer_dma_engine #(
   parameter int DATA_W  = 16,
   parameter int MEM_AW  = 32,
   parameter int BUF_AW  = 10,
   parameter int N_PE    = 32,
   parameter int N_BANK  = 2,
   parameter int MEM_LAT = 1,
   parameter int BUF_LAT = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic                         cmd_op,
   input  logic [MEM_AW-1:0]            cmd_mem_addr,
   input  logic [31:0]                  cmd_words,
   input  logic [$clog2(N_BANK)-1:0]    cmd_bank,
   input  logic [$clog2(N_PE)-1:0]      cmd_chan,
   input  logic                         cmd_append,
   input  logic [BUF_AW-1:0]            cmd_buf_addr,
   input  logic                         ptr_clear,
   output logic                         busy,
   output logic                         done,
   output logic                         err,
   output logic                         mem_re,
   output logic [MEM_AW-1:0]            mem_rd_addr,
   input  logic [DATA_W-1:0]            mem_rd_data,
   output logic                         mem_we,
   output logic [MEM_AW-1:0]            mem_wr_addr,
   output logic [DATA_W-1:0]            mem_wr_data,
   output logic [N_BANK*N_PE-1:0]       buf_w_en,
   output logic [BUF_AW-1:0]            buf_w_addr,
   output logic [DATA_W-1:0]            buf_w_data,
   output logic [N_BANK*N_PE-1:0]       buf_r_en,
   output logic [BUF_AW-1:0]            buf_r_addr,
   input  logic [N_BANK*DATA_W-1:0]     buf_r_data
);
   localparam int NCH = N_BANK * N_PE;
   localparam int IW  = $clog2(NCH);
   localparam int PL  = (MEM_LAT > BUF_LAT) ? MEM_LAT : BUF_LAT;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;
   state_e state_q, state_d;

   logic                      op_q, err_q;
   logic [$clog2(N_BANK)-1:0] bank_q;
   logic [IW-1:0]             sel_q, sel_cmd;
   logic [31:0]               rem_q;
   logic [BUF_AW-1:0]         end_q, start_c, iss_b_q, rd_b_q, ib_n;
   logic [MEM_AW-1:0]         iss_m_q, rd_m_q, im_n;
   logic [PL:1]               vld_pipe_q;
   logic [PL:1][MEM_AW-1:0]   mtag_q;
   logic [PL:1][BUF_AW-1:0]   btag_q;
   logic [BUF_AW-1:0]         bw_addr_q;
   logic [DATA_W-1:0]         bw_data_q, mw_data_q, bank_rd;
   logic [MEM_AW-1:0]         mw_addr_q;
   logic [BUF_AW-1:0]         ptr_q [NCH];
   logic [NCH-1:0]            onehot;
   logic accept, last, req, op_n, wrap_c, wr_buf, wr_mem, drain_empty;

   assign sel_cmd = IW'(cmd_bank) * IW'(N_PE) + IW'(cmd_chan);
   assign start_c = cmd_append ? ptr_q[sel_cmd] : cmd_buf_addr;
   assign wrap_c  = (33'(start_c) + 33'(cmd_words)) > (33'(1) << BUF_AW);
   assign accept  = cmd_valid && (state_q == IDLE);
   assign last    = (rem_q == 32'd1);
   assign req     = (state_q == ISSUE);
   assign op_n    = accept ? cmd_op : op_q;
   assign im_n    = accept ? cmd_mem_addr : iss_m_q + MEM_AW'(1);
   assign ib_n    = accept ? start_c : iss_b_q + BUF_AW'(1);
   assign onehot  = NCH'(1) << sel_q;
   assign wr_buf  = ~op_q & vld_pipe_q[MEM_LAT];
   assign wr_mem  = op_q & vld_pipe_q[BUF_LAT];
   assign bank_rd = buf_r_data[bank_q*DATA_W +: DATA_W];
   assign mem_rd_addr = rd_m_q;
   assign buf_r_addr  = rd_b_q;

   // Only the stages up to the active op's latency carry live returns.
   always_comb begin
      drain_empty = 1'b1;
      for (int i = 1; i <= PL; i++)
         if (vld_pipe_q[i] && i <= (op_q ? BUF_LAT : MEM_LAT)) drain_empty = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = (cmd_words == '0) ? DONE : ISSUE;
         ISSUE:   if (last) state_d = DRAIN;
         DRAIN:   if (drain_empty) state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cmd_ready   = (state_q == IDLE);
      busy        = (state_q != IDLE);
      done        = (state_q == DONE);
      err         = done & err_q;
      mem_re      = req & ~op_q;
      buf_r_en    = (req && op_q) ? onehot : '0;
      buf_w_en    = wr_buf ? onehot : '0;
      buf_w_addr  = wr_buf ? btag_q[MEM_LAT] : bw_addr_q;
      buf_w_data  = wr_buf ? mem_rd_data : bw_data_q;
      mem_we      = wr_mem;
      mem_wr_addr = wr_mem ? mtag_q[BUF_LAT] : mw_addr_q;
      mem_wr_data = wr_mem ? bank_rd : mw_data_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q <= 1'b0; err_q <= 1'b0; bank_q <= '0; sel_q <= '0; rem_q <= '0; end_q <= '0;
         iss_m_q <= '0; iss_b_q <= '0; rd_m_q <= '0; rd_b_q <= '0;
         vld_pipe_q <= '0; mtag_q <= '0; btag_q <= '0;
         bw_addr_q <= '0; bw_data_q <= '0; mw_addr_q <= '0; mw_data_q <= '0;
      end else begin
         if (accept) begin
            op_q   <= cmd_op;
            bank_q <= cmd_bank;
            sel_q  <= sel_cmd;
            err_q  <= wrap_c;
            rem_q  <= cmd_words;
            end_q  <= start_c + cmd_words[BUF_AW-1:0];
         end else if (req) begin
            rem_q <= rem_q - 32'd1;
         end
         // Request address registers advance only when the next cycle issues.
         if (state_d == ISSUE) begin
            iss_m_q <= im_n;
            iss_b_q <= ib_n;
            if (op_n) rd_b_q <= ib_n;
            else      rd_m_q <= im_n;
         end
         vld_pipe_q[1] <= req;
         mtag_q[1]     <= iss_m_q;
         btag_q[1]     <= iss_b_q;
         for (int i = 2; i <= PL; i++) begin
            vld_pipe_q[i] <= vld_pipe_q[i-1];
            mtag_q[i]     <= mtag_q[i-1];
            btag_q[i]     <= btag_q[i-1];
         end
         if (accept) vld_pipe_q <= '0;
         if (wr_buf) begin
            bw_addr_q <= buf_w_addr;
            bw_data_q <= buf_w_data;
         end
         if (wr_mem) begin
            mw_addr_q <= mem_wr_addr;
            mw_data_q <= mem_wr_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NCH; i++) ptr_q[i] <= '0;
      end else if (ptr_clear) begin
         for (int i = 0; i < NCH; i++) ptr_q[i] <= '0;
      end else if (state_q == DONE) begin
         ptr_q[sel_q] <= end_q;
      end
   end
endmodule

// File: doc/buffer_dma_engine.md
# buffer_dma_engine

Parametrised transfer engine between external memory and the on-chip PE buffer banks. It accepts one load or save command at a time over a valid/ready handshake and streams one word per cycle. It tolerates configurable memory and buffer read latencies and keeps per-channel append pointers. It sits between the register-file/program-driver command path and `interface_extmem` / `interface_buffer`, replacing the fixed two-buffer load/save sequencing with an N-bank, latency-aware engine.

## Interface
Parameters:
- `DATA_W` = 16: word width.
- `MEM_AW` = 32: external memory address width.
- `BUF_AW` = 10: buffer address width (`ADDR_RAM`).
- `N_PE` = 32: channels per bank.
- `N_BANK` = 2: number of buffer banks.
- `MEM_LAT` = 1: cycles from `mem_re` to valid `mem_rd_data`, ≥1.
- `BUF_LAT` = 1: cycles from `buf_r_en` to valid `buf_r_data`, ≥1.

Ports:
- `clk` in 1: single clock, all logic rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: engine idle, can accept a command.
- `cmd_op` in 1: 0 = load (mem→buf), 1 = save (buf→mem).
- `cmd_mem_addr` in MEM_AW: first external word address.
- `cmd_words` in 32: word count; 0 is legal.
- `cmd_bank` in $clog2(N_BANK): target bank.
- `cmd_chan` in $clog2(N_PE): target channel.
- `cmd_append` in 1: 1 = start at the channel pointer; 0 = start at `cmd_buf_addr`.
- `cmd_buf_addr` in BUF_AW: explicit buffer start address.
- `ptr_clear` in 1: zero all append pointers (next layer).
- `busy` out 1: command in flight.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: valid with `done`; buffer address wrapped during the transfer.
- `mem_re` out 1, `mem_rd_addr` out MEM_AW, `mem_rd_data` in DATA_W: memory read port.
- `mem_we` out 1, `mem_wr_addr` out MEM_AW, `mem_wr_data` out DATA_W: memory write port.
- `buf_w_en` out N_BANK*N_PE: one-hot write enable, index bank*N_PE+chan.
- `buf_w_addr` out BUF_AW, `buf_w_data` out DATA_W: buffer write address and data.
- `buf_r_en` out N_BANK*N_PE: one-hot read enable.
- `buf_r_addr` out BUF_AW: buffer read address.
- `buf_r_data` in N_BANK*DATA_W: per-bank read data; the engine selects `cmd_bank`.

## Operation
- Reset: state IDLE. All enables, `busy`, `done`, `err` are 0. All addresses, data outputs and pointers are 0. `cmd_ready` is 1.
- Command accepted on `cmd_valid & cmd_ready`; all fields are latched. `cmd_ready` = (state==IDLE). Fields are ignored while not ready.
- States:
  - IDLE→ISSUE on accept with words>0.
  - IDLE→DONE on accept with words==0; no memory or buffer traffic.
  - ISSUE: one request per cycle, counter `k` = 0..words-1. After the last request → DRAIN.
  - DRAIN: hold until the latency pipeline is empty (in-flight valid shift register all zero) → DONE.
  - DONE: pulse `done` (and `err` if set), update the pointer, → IDLE.
- Load:
  - ISSUE drives `mem_re`=1, `mem_rd_addr` = mem_addr+k (mod 2^MEM_AW).
  - A MEM_LAT-deep valid/address shift register tags returning data.
  - Each returning word writes `buf_w_en[bank*N_PE+chan]`, `buf_w_addr` = start+k (mod 2^BUF_AW), `buf_w_data` = `mem_rd_data`.
- Save:
  - ISSUE drives the `buf_r_en` one-hot with `buf_r_addr` = start+k.
  - After BUF_LAT, `mem_we`=1, `mem_wr_addr` = mem_addr+k, `mem_wr_data` = `buf_r_data[bank]`.
- Start address is `ptr[bank][chan]` when `cmd_append`=1, else `cmd_buf_addr`.
- At DONE, `ptr[bank][chan]` ← start+words (mod 2^BUF_AW), for both ops and both start modes.
- `err` = 1 when start+words > 2^BUF_AW: addresses wrap modulo 2^BUF_AW and the transfer still completes.
- `ptr_clear` zeroes all pointers in any state. If it coincides with a DONE update, clear wins. An in-flight transfer keeps its latched start address.
- Reset mid-transfer aborts immediately; outputs return to reset values with no partial `done`.
- `busy` = (state != IDLE).

## Timing
- Accept at edge t. First request (`mem_re` / `buf_r_en`) is registered high in cycle t+1. Requests are in cycles t+1..t+N, one per cycle, no bubbles.
- Load: buffer write for word k occurs in cycle t+1+k+MEM_LAT.
- Save: memory write for word k occurs in cycle t+1+k+BUF_LAT.
- `done` is high in cycle t+2+N+LAT (LAT = MEM_LAT for load, BUF_LAT for save). For N=0, `done` is in cycle t+1.
- `cmd_ready` returns to 1 in the cycle after `done`. Minimum gap between commands is 1 idle cycle.
- Enables are deasserted every cycle without a valid request or return; data and address outputs hold their last value.

## Test plan
- Load, MEM_LAT=1: mem=0x100, words=4, bank 0, chan 3, append, pointer 0 → `buf_w_en` bit 3 high for 4 cycles at addr 0..3 carrying mem[0x100..0x103]; `done` at t+7; ptr[0][3]=4.
- Append chaining: repeat the same command → writes to addr 4..7; ptr=8. Then `ptr_clear` → ptr=0 and the next load starts at 0.
- Save, BUF_LAT=2: bank 1, chan 0, explicit addr 10, words=3, mem=0x200 → `buf_r_en` bit 32 at addr 10..12; `mem_we` at 0x200..0x202 two cycles later with buffer contents; `done` at t+7.
- Zero words: words=0 → no enables asserted, `done` at t+1, pointer unchanged, `err`=0.
- Wrap: BUF_AW=10, explicit addr 1022, words=4 → writes at 1022, 1023, 0, 1; `err`=1 with `done`; ptr=2.
- Abort and coincidence: `rst_n` low mid-load → all outputs 0 and `cmd_ready`=1 immediately. `ptr_clear` in the DONE cycle → pointer reads 0.
